cdc_handshake_tx: RTL and testbench
===================================

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter DATA_W, default 3, width of transferred word.
REQ-002 Parameter TIMEOUT_CYC, default 15, REQ-state cycles before abort; legal range 2..255; used only with CDC_TX_TIMEOUT_EN.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  local request to send in_data.
REQ-006 in_data  input  DATA_W  word to transfer, sampled on accept.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 ack_async  input  1  acknowledge from the far clock domain, asynchronous to clk.
REQ-009 req_out  output  1  4-phase request to the far domain, registered.
REQ-010 tx_data  output  DATA_W  held data bus to the far domain, registered.
REQ-011 done  output  1  one-cycle pulse on handshake completion.
REQ-012 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-013 ack_async SHALL pass through an internal 2-flop synchronizer producing ack_sync; no other logic SHALL read ack_async.
REQ-014 FSM states SHALL be IDLE, REQ_HI (req_out=1, waiting for ack_sync=1), REQ_LO (req_out=0, waiting for ack_sync=0).
REQ-015 in_ready SHALL equal (state==IDLE) AND (ack_sync==0), combinationally.
REQ-016 Accept = in_valid AND in_ready at a rising edge; on that edge tx_data<=in_data, req_out<=1, state<=REQ_HI.
REQ-017 tx_data SHALL stay constant from accept until the next accept; it SHALL NOT change while req_out=1 or in REQ_LO.
REQ-018 In REQ_HI, the first edge sampling ack_sync=1 SHALL set req_out<=0, state<=REQ_LO.
REQ-019 In REQ_LO, the first edge sampling ack_sync=0 SHALL set state<=IDLE and done<=1 for exactly one cycle.
REQ-020 in_valid while not in_ready SHALL be ignored, with no state or data change.
REQ-021 Spurious ack_sync=1 in IDLE SHALL hold in_ready=0 and SHALL NOT change state.
REQ-022 Minimum accept-to-done latency with an immediate far-side echo SHALL be ack round trip + 2 sync cycles per edge + 1; no back-to-back accept SHALL occur before done.
REQ-023 done and err SHALL never be asserted in the same cycle.

Reset
REQ-024 Asserting rst SHALL immediately, without a clock, force state=IDLE, req_out=0, tx_data=0, done=0, err=0, both synchronizer flops=0, timeout counter=0.
REQ-025 Reset mid-handshake SHALL abort the transfer silently, with no done and no err pulse.
REQ-026 After rst deasserts, the first accept is possible on the first edge at which ack_sync=0 and in_valid=1.

Configuration
REQ-027 Macro CDC_TX_TIMEOUT_EN defined: a counter SHALL clear on accept and increment each cycle in REQ_HI.
REQ-028 With the macro defined, if the counter reaches TIMEOUT_CYC-1 in REQ_HI without ack_sync=1, the next edge SHALL set req_out<=0, state<=REQ_LO and err<=1 for one cycle; REQ_LO then exits without a done pulse.
REQ-029 Macro undefined: no counter SHALL be built, err SHALL be tied to 0, and REQ_HI SHALL wait indefinitely.

Verification
REQ-030 Reset, in_valid=1, in_data=3'b101, far model echoes req after 3 clk -> tx_data=101, req_out rises 1 cycle after accept, falls 2 cycles after ack rises, done pulses once, in_ready returns to 1.
REQ-031 in_valid held high with data 3'b010 during an active transfer of 3'b110 -> tx_data stays 110 until done; 010 is accepted only after done.
REQ-032 ack_async forced to 1 while IDLE -> in_ready=0 two cycles later; req_out stays 0; release -> in_ready=1.
REQ-033 rst pulsed mid-cycle while in REQ_HI -> req_out and tx_data go to 0 before the next clk edge; no done and no err.
REQ-034 With CDC_TX_TIMEOUT_EN, TIMEOUT_CYC=15 and ack never asserted -> req_out drops after 15 REQ_HI cycles, err pulses once, done stays 0, in_ready returns to 1.
REQ-035 Without CDC_TX_TIMEOUT_EN, same stimulus for 100 cycles -> req_out stays 1 and err stays 0.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Purpose     : 4-phase req/ack transmitter handing one word at a time to an asynchronous far domain.
// Latency     : accept -> done = far-side echo delays + 2 sync cycles per ack edge + 1 cycle.
// Backpressure: in_ready is low from accept until done, and whenever the synchronized ack is high.
//
// Ports:
//   clk, rst            single rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready   local valid/ready; in_data is captured into tx_data on accept
//   ack_async           far-domain acknowledge, resynchronized internally (2 flops)
//   req_out, tx_data    registered request and held data bus toward the far domain
//   done, err           one-cycle pulses: handshake completed / request timed out
//
// Optional feature: define CDC_TX_TIMEOUT_EN to abort a request that is not acknowledged
// within TIMEOUT_CYC cycles (err pulse, no done). Without it err is constant 0.
module cdc_handshake_tx #(
  parameter int DATA_W      = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              ack_async,
  output logic              req_out,
  output logic [DATA_W-1:0] tx_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ack_meta;
  logic              ack_sync;
  logic              req_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic              done_nxt;
  logic              accept;

  // ack_async is only ever touched by this first flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= ack_async;
      ack_sync <= ack_meta;
    end
  end

  // A stale high ack (far side still releasing, or spurious) blocks new requests.
  assign in_ready = (state == IDLE) && !ack_sync;
  assign accept   = in_valid && in_ready;

`ifdef CDC_TX_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] to_cnt;
  logic [7:0] to_cnt_nxt;
  logic       aborted;
  logic       aborted_nxt;
  logic       err_nxt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_comb begin
    state_nxt   = state;
    req_nxt     = req_out;
    tx_data_nxt = tx_data;
    done_nxt    = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
    aborted_nxt = aborted;
    err_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = REQ_HI;
          req_nxt     = 1'b1;
          tx_data_nxt = in_data;
`ifdef CDC_TX_TIMEOUT_EN
          to_cnt_nxt  = '0;
          aborted_nxt = 1'b0;
`endif
        end
      end
      REQ_HI: begin
`ifdef CDC_TX_TIMEOUT_EN
        to_cnt_nxt = to_cnt + 8'd1;
`endif
        if (ack_sync) begin
          state_nxt = REQ_LO;
          req_nxt   = 1'b0;
        end
`ifdef CDC_TX_TIMEOUT_EN
        // A late ack still completes normally; only a silent far side aborts.
        else if (to_cnt == TO_LAST) begin
          state_nxt   = REQ_LO;
          req_nxt     = 1'b0;
          err_nxt     = 1'b1;
          aborted_nxt = 1'b1;
        end
`endif
      end
      REQ_LO: begin
        // Wait for the far side to drop ack so the next request starts clean.
        if (!ack_sync) begin
          state_nxt = IDLE;
`ifdef CDC_TX_TIMEOUT_EN
          done_nxt  = !aborted;
`else
          done_nxt  = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_out <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_out <= req_nxt;
      tx_data <= tx_data_nxt;
      done    <= done_nxt;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      aborted <= 1'b0;
      err     <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_nxt;
      aborted <= aborted_nxt;
      err     <= err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;

  localparam int DW = 3;
  localparam int TO = 15;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          ack_async;
  logic          req_out;
  logic [DW-1:0] tx_data;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  cdc_handshake_tx #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ack_async(ack_async),
    .req_out  (req_out),
    .tx_data  (tx_data),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Far-side responder: 0 = ack low, 1 = ack stuck high, 2 = echo req_out after far_delay edges.
  int         far_mode  = 0;
  int         far_delay = 0;
  logic [7:0] req_hist  = '0;

  initial begin
    ack_async = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      req_hist = {req_hist[6:0], req_out};
      case (far_mode)
        0:       ack_async = 1'b0;
        1:       ack_async = 1'b1;
        default: ack_async = req_hist[far_delay];
      endcase
    end
  end

  // Reference model: a transfer is "busy" from accept until the far side has released ack;
  // the block sees ack only as the value ack_async had two edges earlier.
  int            cyc       = 0;
  int            m_acc_cyc = 0;
  bit            m_busy    = 0;
  bit            m_req     = 0;
  bit            m_abort   = 0;
  bit            m_done    = 0;
  bit            m_err     = 0;
  bit            m_sync    = 0;
  logic [DW-1:0] m_data    = '0;
  logic [1:0]    m_ackq    = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 0;
      m_req   = 0;
      m_abort = 0;
      m_done  = 0;
      m_err   = 0;
      m_data  = '0;
      m_ackq  = 2'b00;
    end else begin
      cyc++;
      m_sync = m_ackq[1];
      m_done = 0;
      m_err  = 0;
      if (!m_busy) begin
        if (in_valid && !m_sync) begin
          m_busy    = 1;
          m_req     = 1;
          m_abort   = 0;
          m_data    = in_data;
          m_acc_cyc = cyc;
        end
      end else if (m_req) begin
        if (m_sync) m_req = 0;
`ifdef CDC_TX_TIMEOUT_EN
        else if (cyc - m_acc_cyc == TO) begin
          m_req   = 0;
          m_abort = 1;
          m_err   = 1;
        end
`endif
      end else if (!m_sync) begin
        m_busy = 0;
        m_done = !m_abort;
      end
      m_ackq = {m_ackq[0], ack_async};
    end
  end

  int done_seen = 0;

  initial begin
    forever begin
      tick();
      if (!rst) begin
        check("req_out", 32'(req_out), 32'(m_req));
        check("tx_data", 32'(tx_data), 32'(m_data));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("in_ready", 32'(in_ready), 32'(!m_busy && !m_ackq[1]));
        check("done_err_excl", 32'(done && err), 0);
        if (done) done_seen++;
      end
    end
  end

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall;
    int dn;
    int ndone;
    int nerr;
    int hi;
    int d0;
    int r;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    check("rst_req_out", 32'(req_out), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Basic transfer, far side echoes two edges late.
    @(negedge clk);
    far_mode  = 2;
    far_delay = 2;
    in_valid  = 1'b1;
    in_data   = 3'b101;
    tick();
    check("t1_tx_data", 32'(tx_data), 32'h5);
    check("t1_req_rise", 32'(req_out), 1);
    check("t1_model_data", 32'(m_data), 32'h5);
    @(negedge clk);
    in_valid = 1'b0;
    fall = 0; dn = 0; ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (!req_out && fall == 0) fall = n;
      if (done) begin
        ndone++;
        if (dn == 0) dn = n;
      end
    end
    check("t1_req_fall_cyc", 32'(fall), 5);
    check("t1_done_cyc", 32'(dn), 10);
    check("t1_done_count", 32'(ndone), 1);
    check("t1_in_ready", 32'(in_ready), 1);

    // New word held on the input during an active transfer.
    @(negedge clk);
    far_delay = 1;
    in_valid  = 1'b1;
    in_data   = 3'b110;
    tick();
    check("t2_tx_first", 32'(tx_data), 32'h6);
    @(negedge clk);
    in_data = 3'b010;
    wait_done(60, "t2_done");
    check("t2_tx_hold", 32'(tx_data), 32'h6);
    tick();
    check("t2_tx_next", 32'(tx_data), 32'h2);
    check("t2_req_next", 32'(req_out), 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(60, "t2_done2");

    // Spurious ack while idle.
    @(negedge clk);
    far_mode = 1;
    repeat (3) tick();
    check("t3_in_ready_low", 32'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 3'b011;
    repeat (4) tick();
    check("t3_req_stays_low", 32'(req_out), 0);
    check("t3_tx_unchanged", 32'(tx_data), 32'h2);
    check("t3_model_busy", 32'(m_busy), 0);
    @(negedge clk);
    in_valid = 1'b0;
    far_mode = 0;
    repeat (3) tick();
    check("t3_in_ready_back", 32'(in_ready), 1);

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 3'b111;
    tick();
    check("t4_req_hi", 32'(req_out), 1);
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("t4_req_async", 32'(req_out), 0);
    check("t4_tx_async", 32'(tx_data), 0);
    #2;
    rst = 1'b0;
    ndone = 0; nerr = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done) ndone++;
      if (err) nerr++;
    end
    check("t4_no_done", 32'(ndone), 0);
    check("t4_no_err", 32'(nerr), 0);
    check("t4_in_ready", 32'(in_ready), 1);

    // Far side never answers.
    @(negedge clk);
    far_mode = 0;
    in_valid = 1'b1;
    in_data  = 3'b001;
    tick();
    @(negedge clk);
    in_valid = 1'b0;
    fall = 0; nerr = 0; ndone = 0; hi = 0;
`ifdef CDC_TX_TIMEOUT_EN
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (!req_out && fall == 0) fall = n;
      if (err) nerr++;
      if (done) ndone++;
    end
    check("t5_req_fall_cyc", 32'(fall), 15);
    check("t5_err_count", 32'(nerr), 1);
    check("t5_done_count", 32'(ndone), 0);
    check("t5_in_ready", 32'(in_ready), 1);
`else
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (req_out) hi++;
      if (err) nerr++;
    end
    check("t5_req_held", 32'(hi), 100);
    check("t5_err_count", 32'(nerr), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    // Randomized traffic against the model.
    d0 = done_seen;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 32 == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 7) begin
          far_mode  = 2;
          far_delay = int'($urandom_range(0, 6));
        end else if (r == 7) begin
          far_mode = 1;
        end else begin
          far_mode = 0;
        end
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end
    check("rand_activity", 32'((done_seen - d0) >= 20), 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
